ccu_seq_ctrl: RTL and testbench
===============================

// Module: ccu_seq_ctrl
// PURPOSE
//  Sequencer for the nibble-serial ccu cipher core inside tt_um_ccu_goatgate.
//  Collects a BLOCK_NIB-nibble data block and key from the pins using a valid/ready handshake.
//  Streams the block through the core for ROUNDS passes, feeding each pass's output back as the next pass's input.
//  Buffers the result and streams it out using a valid/ready handshake.
// PARAMETERS
//  NIB        4  nibble width (core data/key width)
//  BLOCK_NIB  4  nibbles per block (>=2)
//  ROUNDS     2  core passes per block (>=1)
//  CORE_LAT   1  cycles from core_en-high cycle to matching core_dout (>=1)
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    in_data/in_key nibble offered
//  in_ready   out  1    controller accepts nibble (LOAD only)
//  in_data    in   NIB  plaintext nibble, index 0 first
//  in_key     in   NIB  key nibble paired with in_data
//  out_valid  out  1    out_data holds a result nibble (OUT only)
//  out_ready  in   1    consumer takes out_data
//  out_data   out  NIB  result nibble, index 0 first
//  busy       out  1    high in RUN/WAIT/OUT
//  core_en    out  1    core consumes core_din/core_key this cycle
//  core_din   out  NIB  data nibble to core
//  core_key   out  NIB  key nibble to core
//  core_dout  in   NIB  core result, valid CORE_LAT cycles after core_en
// BEHAVIOUR
//  Reset (async assert, sync release): state=LOAD, all indices/round=0, buffers=0.
//   Output values under reset: in_ready=1, out_valid=0, busy=0, core_en=0, core_din=0, core_key=0, out_data=0.
//  Storage: dbuf[BLOCK_NIB], kbuf[BLOCK_NIB] (NIB each); idx, round counters; CORE_LAT-deep en/idx delay line.
//  LOAD: in_ready=1.
//   Each in_valid&in_ready stores dbuf[idx]=in_data, kbuf[idx]=in_key, idx++.
//   The handshake at idx=BLOCK_NIB-1 moves to RUN next cycle with idx=0, round=0.
//  RUN: exactly BLOCK_NIB cycles, one per idx.
//   core_en=1, core_din=dbuf[idx], core_key=kbuf[idx].
//   After idx=BLOCK_NIB-1 go to WAIT.
//   Outside RUN: core_en=0, core_din=0, core_key=0.
//  Capture: in any cycle where the delayed en bit is 1, dbuf[delayed idx] <= core_dout.
//   Capture runs in RUN and WAIT; each write targets an index already read this pass.
//  WAIT: CORE_LAT cycles until the last capture has landed.
//   Then, if round<ROUNDS-1: round++, idx=0, go to RUN.
//   Otherwise go to OUT with idx=0.
//  OUT: out_valid=1, out_data=dbuf[idx]; out_data is stable while out_valid&!out_ready.
//   Each handshake does idx++. The handshake at idx=BLOCK_NIB-1 goes to LOAD (in_ready=1 next cycle).
//   Elsewhere out_data=0.
//  Latency: LOAD->OUT takes ROUNDS*(BLOCK_NIB+CORE_LAT) cycles.
//  Key buffer is unchanged across rounds; only dbuf is overwritten.
//  in_valid outside LOAD is ignored; no data is lost because in_ready=0.
//  out_ready outside OUT is ignored.
//  Counters never wrap past BLOCK_NIB-1 or ROUNDS-1; all transitions are exact-compare.
//  rst_n low mid-operation aborts immediately and returns to the reset state; the partial block is discarded.
// TESTING
//  Bench core stub: core_dout = register(core_din ^ core_key), which gives CORE_LAT=1.
//  1 ROUNDS=1: load data 1,2,3,4 with key F,0,A,5 -> out_data E,2,9,1 in order;
//    out_valid first rises 5 cycles after the last load handshake.
//  2 ROUNDS=2, same load -> out 1,2,3,4 (double XOR).
//    Check core_en is high 4 cycles per pass with a 1-cycle gap between passes.
//  3 Backpressure: hold out_ready=0 for 3 cycles on nibble 2 -> out_data stays 9, with no skip or duplicate.
//    in_valid pulses during RUN/OUT are ignored.
//  4 Gapped input: in_valid toggling 1,0,1,0,... -> same result as test 1; no RUN entry before the 4th handshake.
//  5 Reset mid-RUN (2nd pass) -> next cycle: in_ready=1, busy=0, core_en=0.
//    A fresh load then gives the correct result.
//  6 Back-to-back blocks: 2nd load starts the cycle after the last out handshake -> both results correct.

Source files
------------

// File: rtl/ccu_seq_ctrl.sv
// ccu_seq_ctrl: sequencer for the nibble-serial ccu cipher core.
// Loads a block of data/key nibbles over a valid/ready handshake, streams the
// block through the core ROUNDS times (feeding results back into the data
// buffer), then streams the result out over a valid/ready handshake.
module ccu_seq_ctrl #(
    parameter int unsigned NIB       = 4,
    parameter int unsigned BLOCK_NIB = 4,
    parameter int unsigned ROUNDS    = 2,
    parameter int unsigned CORE_LAT  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NIB-1:0] in_data,
    input  logic [NIB-1:0] in_key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [NIB-1:0] out_data,
    output logic           busy,
    output logic           core_en,
    output logic [NIB-1:0] core_din,
    output logic [NIB-1:0] core_key,
    input  logic [NIB-1:0] core_dout
);

    localparam int unsigned IW = $clog2(BLOCK_NIB);
    localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int unsigned WW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    localparam logic [IW-1:0] IDX_LAST  = IW'(BLOCK_NIB - 1);
    localparam logic [RW-1:0] RND_LAST  = RW'(ROUNDS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [RW-1:0]   round_q, round_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;

    logic [NIB-1:0]  dbuf_q [BLOCK_NIB];
    logic [NIB-1:0]  kbuf_q [BLOCK_NIB];

    logic [CORE_LAT-1:0] en_dly_q;
    logic [IW-1:0]       idx_dly_q [CORE_LAT];

    logic load_hs;

    // State, index, round and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            round_q <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic and all handshake/core-facing outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        round_d   = round_q;
        wcnt_d    = wcnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        core_en   = 1'b0;
        core_din  = '0;
        core_key  = '0;
        load_hs   = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load_hs = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                        idx_d   = '0;
                        round_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                core_en  = 1'b1;
                core_din = dbuf_q[idx_q];
                core_key = kbuf_q[idx_q];
                if (idx_q == IDX_LAST) begin
                    state_d = S_WAIT;
                    idx_d   = '0;
                    wcnt_d  = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    idx_d = '0;
                    if (round_q != RND_LAST) begin
                        round_d = round_q + 1'b1;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_OUT;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = dbuf_q[idx_q];
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
                idx_d   = '0;
            end
        endcase
    end

    // Core enable/index delay line aligning captures with core_dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_dly_q <= '0;
            for (int unsigned i = 0; i < CORE_LAT; i++) begin
                idx_dly_q[i] <= '0;
            end
        end else begin
            en_dly_q[0]  <= core_en;
            idx_dly_q[0] <= idx_q;
            for (int unsigned i = 1; i < CORE_LAT; i++) begin
                en_dly_q[i]  <= en_dly_q[i-1];
                idx_dly_q[i] <= idx_dly_q[i-1];
            end
        end
    end

    // Data/key buffers: filled from the pins, data overwritten by core results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BLOCK_NIB; i++) begin
                dbuf_q[i] <= '0;
                kbuf_q[i] <= '0;
            end
        end else begin
            if (load_hs) begin
                dbuf_q[idx_q] <= in_data;
                kbuf_q[idx_q] <= in_key;
            end
            if (en_dly_q[CORE_LAT-1]) begin
                dbuf_q[idx_dly_q[CORE_LAT-1]] <= core_dout;
            end
        end
    end

endmodule

// File: tb/tb_ccu_seq_ctrl.sv
// Testbench for ccu_seq_ctrl: one instance with ROUNDS=1 and one with ROUNDS=2,
// each with an XOR core stub, sharing input-side stimulus.
module tb_ccu_seq_ctrl;

    localparam int BN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] in_data = '0;
    logic [3:0] in_key = '0;

    logic       in_ready1, out_valid1, busy1, core_en1;
    logic [3:0] out_data1, core_din1, core_key1, core_dout1;
    logic       in_ready2, out_valid2, busy2, core_en2;
    logic [3:0] out_data2, core_din2, core_key2, core_dout2;

    int checks = 0;
    int errors = 0;

    logic [3:0] blk_d [BN];
    logic [3:0] blk_k [BN];

    always #5 clk = ~clk;

    // Core stubs: registered XOR gives a one-cycle latency.
    always_ff @(posedge clk) begin
        core_dout1 <= core_din1 ^ core_key1;
        core_dout2 <= core_din2 ^ core_key2;
    end

    ccu_seq_ctrl #(.NIB(4), .BLOCK_NIB(BN), .ROUNDS(1), .CORE_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .busy(busy1), .core_en(core_en1), .core_din(core_din1), .core_key(core_key1),
        .core_dout(core_dout1)
    );

    ccu_seq_ctrl #(.NIB(4), .BLOCK_NIB(BN), .ROUNDS(2), .CORE_LAT(1)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .busy(busy2), .core_en(core_en2), .core_din(core_din2), .core_key(core_key2),
        .core_dout(core_dout2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: data nibble after a number of passes through an XOR core.
    function automatic logic [3:0] ref_nib(input logic [3:0] d, input logic [3:0] k, input int passes);
        logic [3:0] r;
        r = d;
        for (int p = 0; p < passes; p++) r = r ^ k;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dir();
        blk_d[0] = 4'h1; blk_d[1] = 4'h2; blk_d[2] = 4'h3; blk_d[3] = 4'h4;
        blk_k[0] = 4'hF; blk_k[1] = 4'h0; blk_k[2] = 4'hA; blk_k[3] = 4'h5;
    endtask

    task automatic set_rand();
        for (int i = 0; i < BN; i++) begin
            blk_d[i] = 4'($urandom);
            blk_k[i] = 4'($urandom);
        end
    endtask

    task automatic load(input bit gapped);
        for (int i = 0; i < BN; i++) begin
            in_valid = 1'b1;
            in_data  = blk_d[i];
            in_key   = blk_k[i];
            chk("load_in_ready1", in_ready1, 1);
            chk("load_in_ready2", in_ready2, 1);
            step();
            if (gapped && i < BN - 1) begin
                in_valid = 1'b0;
                in_data  = 4'($urandom);
                step();
                chk("gap_busy1", busy1, 0);
                chk("gap_busy2", busy2, 0);
            end
        end
        in_valid = 1'b0;
    endtask

    // Runs from the cycle after the last load handshake until both outputs drain.
    task automatic collect(input int stall_n, input bit pulses);
        int c = 0, n1 = 0, n2 = 0, f1 = -1, f2 = -1, st = 0, pass, pos;
        logic exp_en;
        while ((n1 < BN || n2 < BN) && c < 200) begin
            if (n1 == 2 && out_valid1 === 1'b1 && st < stall_n) begin
                out_ready = 1'b0;
                st++;
                chk("stall_hold", out_data1, ref_nib(blk_d[2], blk_k[2], 1));
            end else begin
                out_ready = 1'b1;
            end
            if (pulses && n1 < BN && n2 < BN) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 4'($urandom);
                in_key   = 4'($urandom);
                if (in_valid) begin
                    chk("ignored_rdy1", in_ready1, 0);
                    chk("ignored_rdy2", in_ready2, 0);
                end
            end else begin
                in_valid = 1'b0;
            end
            if (f1 < 0 && out_valid1 === 1'b1) f1 = c;
            if (f2 < 0 && out_valid2 === 1'b1) f2 = c;
            pass = c / (BN + 1);
            pos  = c % (BN + 1);
            exp_en = (pass < 1) && (pos < BN);
            chk("core_en1", core_en1, exp_en);
            if (exp_en) begin
                chk("core_din1", core_din1, ref_nib(blk_d[pos], blk_k[pos], pass));
                chk("core_key1", core_key1, blk_k[pos]);
            end
            exp_en = (pass < 2) && (pos < BN);
            chk("core_en2", core_en2, exp_en);
            if (exp_en) begin
                chk("core_din2", core_din2, ref_nib(blk_d[pos], blk_k[pos], pass));
                chk("core_key2", core_key2, blk_k[pos]);
            end else begin
                chk("core_din2_idle", core_din2, 0);
            end
            if (out_valid1 !== 1'b1) chk("out1_idle", out_data1, 0);
            if (out_valid1 === 1'b1 && out_ready) begin
                chk("out1", out_data1, ref_nib(blk_d[n1], blk_k[n1], 1));
                n1++;
            end
            if (out_valid2 === 1'b1 && out_ready) begin
                chk("out2", out_data2, ref_nib(blk_d[n2], blk_k[n2], 2));
                n2++;
            end
            step();
            c++;
        end
        chk("drain_done", (n1 == BN && n2 == BN), 1);
        chk("latency1", f1, 1 * (BN + 1));
        chk("latency2", f2, 2 * (BN + 1));
        chk("stall_count", st, stall_n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #12;
        chk("rst_in_ready2", in_ready2, 1);
        chk("rst_out_valid2", out_valid2, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_core_en2", core_en2, 0);
        chk("rst_core_din2", core_din2, 0);
        chk("rst_core_key2", core_key2, 0);
        chk("rst_out_data2", out_data2, 0);
        chk("rst_in_ready1", in_ready1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed block with backpressure on nibble 2 and ignored in_valid pulses.
        set_dir();
        load(1'b0);
        collect(3, 1'b1);

        // Same block loaded with gaps; followed back-to-back by random blocks.
        load(1'b1);
        collect(0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            set_rand();
            load(1'($urandom_range(0, 1)));
            collect(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset during the second pass of the two-round instance.
        set_rand();
        load(1'b0);
        repeat (6) step();
        chk("pre_rst_en2", core_en2, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready2", in_ready2, 1);
        chk("arst_busy2", busy2, 0);
        chk("arst_core_en2", core_en2, 0);
        chk("arst_out_valid1", out_valid1, 0);
        chk("arst_out_data1", out_data1, 0);
        step();
        chk("rst_next_in_ready2", in_ready2, 1);
        chk("rst_next_busy2", busy2, 0);
        chk("rst_next_core_en2", core_en2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_rand();
        load(1'b0);
        collect(2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
